// File: rtl/logic_unit_pkg.sv
// Shared op-code type and encoding constants for the pipelined logic unit.
`timescale 1ns/1ps
package logic_unit_pkg;

   localparam int OP_BITS = 3;

   // Op-code encoding; each constant is the value presented on the op port.
   typedef enum logic [OP_BITS-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_NOT  = 3'b010,
      OP_XOR  = 3'b011,
      OP_XNOR = 3'b100,
      OP_NAND = 3'b101,
      OP_NOR  = 3'b110,
      OP_PASS = 3'b111
   } op_t;

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational bitwise evaluator: y = f(op, a, b), no carries between bits.
`timescale 1ns/1ps
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Select the bitwise function; NOT and PASS ignore b.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_PASS: y = a;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes, result chaining
// and a saturating count of completed output transfers.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds its payload stable while valid && !ready, and ready
// may depend combinationally on the downstream ready only.
`timescale 1ns/1ps
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             chain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] txn_count
);

   // Stage 1 holding registers
   logic             s1_valid;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_chain;

   logic             s2_load;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] eff_b;
   logic [WIDTH-1:0] core_y;

   // S2 advances when it is empty or its result is being taken this cycle;
   // S1 can accept whenever it is empty or is emptying into S2.
   always_comb begin
      s2_load  = s1_valid && (!out_valid || out_ready);
      in_ready = !s1_valid || s2_load;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      // Chaining uses the result register as it stands when S2 loads, which
      // is always the immediately preceding result.
      eff_b    = s1_chain ? y : s1_b;
   end

   logic_unit_core #(.WIDTH(WIDTH)) u_core (
      .op (s1_op),
      .a  (s1_a),
      .b  (eff_b),
      .y  (core_y)
   );

   // Stage 1: capture the request on input transfer, drop it once moved to S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_AND;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_chain <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= op_t'(op);
            s1_a     <= a;
            s1_b     <= b;
            s1_chain <= chain;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: register the result and its flags; they hold until the next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         zero      <= 1'b1;
         parity    <= 1'b0;
      end else begin
         if (s2_load) begin
            out_valid <= 1'b1;
            y         <= core_y;
            zero      <= (core_y == '0);
            parity    <= ^core_y;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Count completed output transfers, sticking at the all-ones value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count <= '0;
      end else if (out_fire && (txn_count != {CNT_W{1'b1}})) begin
         txn_count <= txn_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: driver pushes expected results into a
// queue on acceptance, an independent monitor pops and compares on each
// output transfer.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         chain;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zero;
  logic         parity;
  logic [7:0]   txn_count;

  // second instance with a 2-bit counter sharing the same stimulus
  logic         in_ready2;
  logic         out_valid2;
  logic [W-1:0] y2;
  logic         zero2;
  logic         parity2;
  logic [1:0]   txn_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic lat_chk = 1'b0;

  logic [W+1:0] exp_q[$];
  int           lat_q[$];

  logic [W-1:0] tab_y [8];

  logic_unit_pipe #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .chain(chain), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero), .parity(parity),
    .txn_count(txn_count)
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .chain(chain), .out_valid(out_valid2),
    .out_ready(out_ready), .y(y2), .zero(zero2), .parity(parity2),
    .txn_count(txn_count2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    chain = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    if (check) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_y", y, 8'h00);
      chk("rst_zero", zero, 1'b1);
      chk("rst_parity", parity, 1'b0);
      chk("rst_txn_count", txn_count, 8'd0);
      chk("rst_txn_count2", txn_count2, 2'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    if (check) chk("rst_in_ready", in_ready, 1'b1);
  endtask

  // driver: offer one request, push its expected result when accepted
  task automatic send(input logic [2:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic ch, input logic [W-1:0] ey);
    int tries;
    logic acc;
    tries = 0;
    acc = 1'b0;
    @(negedge clk);
    op = o; a = aa; b = bb; chain = ch; in_valid = 1'b1;
    while (!acc && tries < 50) begin
      #2;
      acc = in_ready;
      if (acc) begin
        exp_q.push_back({ey, (ey == '0), ^ey});
        lat_q.push_back(cyc);
      end
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        tries++;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    #2;
  endtask

  // monitor: compare on every output transfer, and hold-stability while stalled
  initial begin
    logic [W+1:0] e;
    int           la;
    logic         prev_stall;
    logic [W-1:0] prev_y;
    logic [1:0]   prev_zp;
    prev_stall = 1'b0;
    prev_y = '0;
    prev_zp = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_y", y, prev_y);
          chk("hold_flags", {zero, parity}, prev_zp);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1'b1, 1'b0);
          end else begin
            e  = exp_q.pop_front();
            la = lat_q.pop_front();
            chk("y", y, e[W+1:2]);
            chk("zero", zero, e[1]);
            chk("parity", parity, e[0]);
            if (lat_chk) chk("latency", cyc - la, 2);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_y = y;
        prev_zp = {zero, parity};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; chain = 1'b0;
    out_ready = 1'b1;
    tab_y[0] = 8'h05; tab_y[1] = 8'hAF; tab_y[2] = 8'h5A; tab_y[3] = 8'hAA;
    tab_y[4] = 8'h55; tab_y[5] = 8'hFA; tab_y[6] = 8'h50; tab_y[7] = 8'hA5;

    do_reset(1'b1);

    // all eight ops back-to-back, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, 1'b0, tab_y[i]);
    drain();
    lat_chk = 1'b0;
    chk("txn_count_8", txn_count, 8'd8);
    chk("txn_count2_sat", txn_count2, 2'd3);

    // zero / parity flags
    do_reset(1'b0);
    send(3'b011, 8'h3C, 8'h3C, 1'b0, 8'h00);
    send(3'b000, 8'h07, 8'hFF, 1'b0, 8'h07);
    drain();
    chk("txn_count_2", txn_count, 8'd2);
    chk("txn_count2_2", txn_count2, 2'd2);

    // chaining back-to-back
    send(3'b001, 8'h01, 8'h00, 1'b0, 8'h01);
    send(3'b011, 8'h03, 8'h00, 1'b1, 8'h02);
    send(3'b000, 8'hFF, 8'h00, 1'b1, 8'h02);
    drain();

    // backpressure: two accepted, third held
    do_reset(1'b0);
    out_ready = 1'b0;
    fork
      begin
        send(3'b111, 8'h11, 8'h00, 1'b0, 8'h11);
        send(3'b010, 8'h0F, 8'h00, 1'b0, 8'hF0);
        send(3'b110, 8'h80, 8'h01, 1'b0, 8'h7E);
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("txn_count_3", txn_count, 8'd3);

    // reset with both stages full, then chained request sees b = 0
    do_reset(1'b0);
    out_ready = 1'b0;
    send(3'b001, 8'h33, 8'h44, 1'b0, 8'h77);
    send(3'b011, 8'hFF, 8'h00, 1'b0, 8'hFF);
    @(negedge clk);
    #2;
    chk("full_in_ready", in_ready, 1'b0);
    do_reset(1'b1);
    out_ready = 1'b1;
    send(3'b011, 8'h5A, 8'h00, 1'b1, 8'h5A);
    drain();
    chk("txn_count_post_rst", txn_count, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, width of the transaction counter.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present on a, b, op, chain.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 op  input  3  operation select; encoding per REQ-013.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 chain  input  1  when 1, replace b with the previous result.
REQ-011 out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 y  output  WIDTH  result; zero  output  1  (y == 0); parity  output  1  XOR-reduction of y; txn_count  output  CNT_W  completed output handshakes.

Function
REQ-013 op encoding: 000 AND, 001 OR, 010 NOT (~a, b ignored), 011 XOR, 100 XNOR, 101 NAND, 110 NOR, 111 PASS (a).
REQ-014 All operations SHALL be bitwise across WIDTH; no carries; no bit depends on another bit position.
REQ-015 Input transfer SHALL occur on a rising edge with in_valid && in_ready; output transfer with out_valid && out_ready.
REQ-016 Two register stages: S1 captures {op, a, b, chain}; S2 computes and registers y, zero, parity.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput 1 per cycle.
REQ-018 S2 SHALL load when S1 is valid and (S2 empty or out_ready); S1 SHALL load when in_valid and in_ready.
REQ-019 in_ready SHALL equal !S1_valid || S2 load condition; combinational dependence on out_ready is permitted, no other input.
REQ-020 With chain = 1, the effective b SHALL be the current y register value at the moment S2 loads; back-to-back chained requests SHALL use the immediately preceding result.
REQ-021 y, zero, parity SHALL hold their value after the output transfer until the next S2 load.
REQ-022 While out_valid && !out_ready, y, zero, parity and out_valid SHALL remain stable.
REQ-023 Results SHALL leave in acceptance order; no request dropped or duplicated.
REQ-024 txn_count SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1.
REQ-025 in_valid with in_ready = 0 SHALL have no effect; the requester holds the request.

Reset
REQ-026 While rst_n = 0: S1/S2 valid = 0, out_valid = 0, y = 0, zero = 1, parity = 0, txn_count = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight requests; the first chained request after reset SHALL use b = 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Package logic_unit_pkg SHALL hold the op encoding constants and the op-code type.
REQ-030 Sub-module logic_unit_core SHALL be the purely combinational op/a/b -> y evaluator, instanced once in S2.

Verification (WIDTH=8)
REQ-031 a=0xA5, b=0x0F, out_ready=1, ops 000..111 back-to-back -> y = 05,AF,5A,AA,55,FA,50,A5 in order, each 2 cycles after its input transfer.
REQ-032 XOR with a=b=0x3C -> y=0x00, zero=1, parity=0; AND a=0x07 b=0xFF -> y=0x07, zero=0, parity=1.
REQ-033 OR a=0x01 b=0x00 chain=0, then XOR a=0x03 chain=1, then AND a=0xFF chain=1, back-to-back -> y = 0x01, 0x02, 0x02.
REQ-034 out_ready=0, three requests offered -> two accepted, in_ready=0 while the third is held; out_ready=1 -> three results in order, txn_count = 3.
REQ-035 rst_n pulsed low with both stages full -> out_valid=0, y=0, zero=1, txn_count=0; next chained XOR a=0x5A -> y=0x5A.
REQ-036 CNT_W=2, five output transfers -> txn_count = 3 (saturated).
